// File: rtl/pixel_painter.sv
// pixel_painter: write-side engine for the 128x128 3-bit pixel frame store.
// It turns brush samples into single-pixel RAM writes covering a
// (2R+1)x(2R+1) square around the brush, or erases the whole canvas.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   brush           level, brush touching canvas
//   newColor[2:0]   paint colour code
//   wx, wy [7:0]    brush position; values >= 2^COORD_W are off-canvas
//   clear           single-cycle request to erase the canvas
//   we              RAM write enable (registered)
//   waddr           RAM write address {y,x} (registered)
//   wdata[2:0]      RAM write data (registered)
//   busy            high while a paint or clear is running (registered)
//   done            one-cycle pulse after the last paint/clear cycle (registered)
module pixel_painter #(
    parameter int unsigned COORD_W     = 7,
    parameter int unsigned BRUSH_R     = 1,
    parameter logic [2:0]  ERASE_COLOR = 3'd0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   brush,
    input  logic [2:0]             newColor,
    input  logic [7:0]             wx,
    input  logic [7:0]             wy,
    input  logic                   clear,
    output logic                   we,
    output logic [2*COORD_W-1:0]   waddr,
    output logic [2:0]             wdata,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned AW     = 2 * COORD_W;
    localparam int unsigned CW     = COORD_W + 2;          // signed intermediate width
    localparam int unsigned SIDE   = 2 * BRUSH_R + 1;
    localparam int unsigned LAST   = SIDE - 1;
    localparam int unsigned IW     = $clog2(SIDE + 1);
    localparam int unsigned CANVAS = 1 << COORD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAINT = 2'd1,
        CLEAR = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        ix_q, ix_d, iy_q, iy_d;
    logic [COORD_W-1:0]   cx_q, cx_d, cy_q, cy_d;
    logic [2:0]           col_q, col_d;
    logic                 rec_valid_q, rec_valid_d;
    logic                 we_q, we_d;
    logic [AW-1:0]        waddr_q, waddr_d;
    logic [2:0]           wdata_q, wdata_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Scan position to emit next: origin when starting, else advance x then y.
    logic                 paint_last;
    logic [IW-1:0]        pos_x, pos_y;
    logic [COORD_W-1:0]   base_x, base_y;
    logic signed [CW-1:0] px, py;
    logic                 pos_on;
    logic [AW-1:0]        pos_addr;

    assign paint_last = (ix_q == IW'(LAST)) && (iy_q == IW'(LAST));
    assign pos_x      = (state_q != PAINT) ? '0 : ((ix_q == IW'(LAST)) ? '0 : ix_q + IW'(1));
    assign pos_y      = (state_q != PAINT) ? '0 : ((ix_q == IW'(LAST)) ? iy_q + IW'(1) : iy_q);
    assign base_x     = (state_q == PAINT) ? cx_q : wx[COORD_W-1:0];
    assign base_y     = (state_q == PAINT) ? cy_q : wy[COORD_W-1:0];

    assign px = $signed(CW'(base_x)) + $signed(CW'(pos_x)) - $signed(CW'(BRUSH_R));
    assign py = $signed(CW'(base_y)) + $signed(CW'(pos_y)) - $signed(CW'(BRUSH_R));

    // On canvas iff 0 <= v <= 2^COORD_W-1, i.e. sign and overflow bits clear.
    assign pos_on   = (px[CW-1:COORD_W] == '0) && (py[CW-1:COORD_W] == '0);
    assign pos_addr = {py[COORD_W-1:0], px[COORD_W-1:0]};

    // A stroke starts on an on-canvas touch that differs from the last stroke.
    logic on_canvas_in, rec_differs, stroke_start;
    assign on_canvas_in = ({1'b0, wx} < 9'(CANVAS)) && ({1'b0, wy} < 9'(CANVAS));
    assign rec_differs  = !rec_valid_q || (wx != 8'(cx_q)) || (wy != 8'(cy_q))
                          || (newColor != col_q);
    assign stroke_start = brush && on_canvas_in && rec_differs;

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ix_q        <= '0;
            iy_q        <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            col_q       <= '0;
            rec_valid_q <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ix_q        <= ix_d;
            iy_q        <= iy_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            col_q       <= col_d;
            rec_valid_q <= rec_valid_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next state and next registered outputs (the write shown next cycle).
    always_comb begin
        state_d     = state_q;
        ix_d        = ix_q;
        iy_d        = iy_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        col_d       = col_q;
        rec_valid_d = rec_valid_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = CLEAR;
                    we_d    = 1'b1;
                    waddr_d = '0;
                    wdata_d = ERASE_COLOR;
                    busy_d  = 1'b1;
                end else if (stroke_start) begin
                    state_d     = PAINT;
                    cx_d        = wx[COORD_W-1:0];
                    cy_d        = wy[COORD_W-1:0];
                    col_d       = newColor;
                    rec_valid_d = 1'b1;
                    ix_d        = '0;
                    iy_d        = '0;
                    busy_d      = 1'b1;
                    we_d        = pos_on;
                    if (pos_on) begin
                        waddr_d = pos_addr;
                        wdata_d = newColor;
                    end
                end else if (!brush) begin
                    // Lifting the brush lets a new press at the same spot repaint.
                    rec_valid_d = 1'b0;
                end
            end

            PAINT: begin
                if (clear) begin
                    // Abort the paint silently; no done pulse for it.
                    state_d = CLEAR;
                    we_d    = 1'b1;
                    waddr_d = '0;
                    wdata_d = ERASE_COLOR;
                    busy_d  = 1'b1;
                end else if (paint_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    ix_d   = pos_x;
                    iy_d   = pos_y;
                    busy_d = 1'b1;
                    we_d   = pos_on;
                    if (pos_on) begin
                        waddr_d = pos_addr;
                        wdata_d = col_q;
                    end
                end
            end

            CLEAR: begin
                // waddr_q doubles as the clear address counter.
                if (waddr_q == '1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = waddr_q + AW'(1);
                    wdata_d = ERASE_COLOR;
                    busy_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_pixel_painter.sv
// tb_pixel_painter: directed and randomized checks of pixel_painter against
// a square-brush / full-clear reference computed with plain arithmetic.
module tb_pixel_painter;

    localparam int CW    = 7;
    localparam int R     = 1;
    localparam int SIZE  = 1 << CW;

    logic          clk = 1'b0;
    logic          reset;
    logic          brush;
    logic [2:0]    newColor;
    logic [7:0]    wx;
    logic [7:0]    wy;
    logic          clear;
    logic          we;
    logic [13:0]   waddr;
    logic [2:0]    wdata;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    pixel_painter dut (
        .clk      (clk),
        .reset    (reset),
        .brush    (brush),
        .newColor (newColor),
        .wx       (wx),
        .wy       (wy),
        .clear    (clear),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Advance one cycle and settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: every position of the square in raster order, one per cycle,
    // written only when on the canvas, followed by the done pulse.
    task automatic exp_stroke(input int x, input int y, input int col);
        int px, py;
        for (int dy = -R; dy <= R; dy++) begin
            for (int dx = -R; dx <= R; dx++) begin
                tick();
                px = x + dx;
                py = y + dy;
                if (px >= 0 && px < SIZE && py >= 0 && py < SIZE) begin
                    chk("paint_we", 32'(we), 32'(1));
                    chk("paint_addr", 32'(waddr), 32'(py * SIZE + px));
                    chk("paint_data", 32'(wdata), 32'(col));
                end else begin
                    chk("paint_clip_we", 32'(we), 32'(0));
                end
                chk("paint_busy", 32'(busy), 32'(1));
                chk("paint_nodone", 32'(done), 32'(0));
            end
        end
        tick();
        chk("done_pulse", 32'(done), 32'(1));
        chk("done_busy", 32'(busy), 32'(0));
        chk("done_we", 32'(we), 32'(0));
    endtask

    task automatic expect_quiet(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_we"}, 32'(we), 32'(0));
            chk({tag, "_busy"}, 32'(busy), 32'(0));
        end
    endtask

    task automatic set_brush(input logic b, input int x, input int y, input int col);
        brush    = b;
        wx       = 8'(x);
        wy       = 8'(y);
        newColor = 3'(col);
    endtask

    initial begin
        int x, y, col;
        reset    = 1'b1;
        brush    = 1'b0;
        newColor = 3'd0;
        wx       = 8'd0;
        wy       = 8'd0;
        clear    = 1'b0;

        tick();
        tick();
        chk("rst_we", 32'(we), 32'(0));
        chk("rst_waddr", 32'(waddr), 32'(0));
        chk("rst_wdata", 32'(wdata), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        reset = 1'b0;

        // Held stroke paints once only.
        set_brush(1'b1, 10, 20, 2);
        exp_stroke(10, 20, 2);
        expect_quiet(3, "held");

        // Colour change repaints; lift-and-press at same point repaints.
        newColor = 3'd5;
        exp_stroke(10, 20, 5);
        brush = 1'b0;
        expect_quiet(1, "lift");
        brush = 1'b1;
        exp_stroke(10, 20, 5);

        // Corner clipping.
        set_brush(1'b1, 0, 0, 4);
        exp_stroke(0, 0, 4);

        // Off-canvas brush positions.
        set_brush(1'b1, 130, 5, 1);
        expect_quiet(3, "offx");
        set_brush(1'b1, 5, 200, 1);
        expect_quiet(3, "offy");

        // Randomized strokes, biased toward canvas edges.
        for (int k = 0; k < 30; k++) begin
            brush = 1'b0;
            expect_quiet(1, "rnd_gap");
            case ($urandom_range(0, 4))
                0:       x = 0;
                1:       x = SIZE - 1;
                2:       x = int'($urandom_range(128, 255));
                default: x = int'($urandom_range(0, 127));
            endcase
            case ($urandom_range(0, 4))
                0:       y = 0;
                1:       y = SIZE - 1;
                2:       y = int'($urandom_range(128, 255));
                default: y = int'($urandom_range(0, 127));
            endcase
            col = int'($urandom_range(0, 7));
            set_brush(1'b1, x, y, col);
            if (x < SIZE && y < SIZE) exp_stroke(x, y, col);
            else expect_quiet(2, "rnd_off");
        end

        // Full clear from IDLE.
        brush = 1'b0;
        expect_quiet(1, "pre_clr");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < SIZE * SIZE; i++) begin
            chk("clr_beat", 32'({we, waddr, wdata, busy, done}),
                32'({1'b1, 14'(i), 3'd0, 1'b1, 1'b0}));
            tick();
        end
        chk("clr_done", 32'(done), 32'(1));
        chk("clr_done_busy", 32'(busy), 32'(0));
        chk("clr_done_we", 32'(we), 32'(0));

        // Clear on the 4th paint cycle aborts the paint.
        set_brush(1'b1, 50, 60, 3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_pre_we", 32'(we), 32'(1));
            chk("abort_pre_addr", 32'(waddr), 32'((59 + i / 3) * SIZE + 49 + i % 3));
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("abort_clr0", 32'({we, waddr, wdata, busy, done}),
            32'({1'b1, 14'd0, 3'd0, 1'b1, 1'b0}));
        for (int i = 1; i <= 500; i++) begin
            tick();
            chk("abort_clr", 32'({we, waddr, wdata, busy, done}),
                32'({1'b1, 14'(i), 3'd0, 1'b1, 1'b0}));
        end

        // Asynchronous reset mid-clear, then identical held stroke repaints.
        reset = 1'b1;
        #1;
        chk("arst_we", 32'(we), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_waddr", 32'(waddr), 32'(0));
        chk("arst_done", 32'(done), 32'(0));
        tick();
        tick();
        reset = 1'b0;
        exp_stroke(50, 60, 3);
        expect_quiet(2, "post_rst_held");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_painter.md
Name: pixel_painter

Overview:
- Write-side engine for the 128x128 3-bit pixel frame store that the VGA raster path reads.
- Converts brush samples (wx, wy, brush, newColor) into a sequence of single-pixel RAM writes: a (2R+1)x(2R+1) square centred on the brush, or a full-canvas clear.
- Drives the write port of the shared simple-dual-port pixel RAM: one write per cycle, address {y[6:0],x[6:0]}.

Parameters:
- COORD_W, 7, coordinate bits per axis; canvas is 2^COORD_W square, RAM depth 2^(2*COORD_W).
- BRUSH_R, 1, brush radius in pixels; square side 2*BRUSH_R+1.
- ERASE_COLOR, 3'd0, colour code written by clear.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- brush  in  1  level; brush touching canvas
- newColor  in  3  paint colour code
- wx  in  8  brush x; values >= 2^COORD_W are off-canvas
- wy  in  8  brush y; values >= 2^COORD_W are off-canvas
- clear  in  1  single-cycle request to erase the whole canvas
- we  out  1  RAM write enable
- waddr  out  2*COORD_W  RAM write address {y,x}
- wdata  out  3  RAM write data
- busy  out  1  high while PAINT or CLEAR in progress
- done  out  1  one-cycle pulse after the last cycle of a paint or clear

Behaviour:
- All outputs are registered. Reset value: we=0, waddr=0, wdata=0, busy=0, done=0. State=IDLE; last-stroke record invalid.
- States: IDLE, PAINT, CLEAR.
- IDLE priority: clear > stroke.
  - clear=1 -> CLEAR.
  - Else a stroke starts when brush=1, wx<128, wy<128, and (record invalid, or {wx,wy,newColor} differs from the record).
  - On start, capture cx=wx, cy=wy, col=newColor and update the record.
  - brush=0 in IDLE invalidates the record, so a new press at the same point repaints.
- Latency: request sampled in IDLE cycle N -> first write (we=1) in cycle N+1; busy=1 from N+1.
- PAINT:
  - Scans dy = -R..+R (outer), dx = -R..+R (inner): exactly (2R+1)^2 cycles, one position per cycle.
  - Position (cx+dx, cy+dy) in range 0..127 on both axes: we=1, waddr={y,x}, wdata=col.
  - Position outside the canvas: we=0. The cycle is still consumed; there is no wrap-around.
  - After the last position: state=IDLE, busy=0, we=0, done=1 for one cycle. IDLE evaluates requests in that same cycle.
- CLEAR:
  - 16384 cycles, we=1, wdata=ERASE_COLOR, waddr ascending 0..16383.
  - Then done pulse and IDLE, as for PAINT.
- Simultaneous events:
  - clear during PAINT aborts the paint (remaining pixels are not written). CLEAR starts next cycle at address 0, and no done pulse is issued for the aborted paint.
  - clear during CLEAR is ignored.
  - brush changes during PAINT/CLEAR are not queued; the stroke condition is re-evaluated in the next IDLE cycle against the record.
- Coordinate arithmetic uses signed 9-bit intermediates; the clip check is 0 <= v <= 2^COORD_W-1.
- Asynchronous reset mid-operation: immediate return to reset values and IDLE; partial writes are left in RAM.
- waddr/wdata are don't-care when we=0, but hold their last value (no toggling) in IDLE.

Test Plan:
- After reset, brush=1, wx=10, wy=20, newColor=3'd2, held: 9 consecutive cycles with we=1, waddr 2441,2442,2443,2569,2570,2571,2697,2698,2699, wdata=2; done pulse on cycle 10. No second stroke while the inputs remain unchanged.
- brush=1 at (0,0), colour 3'd4: 9 busy cycles, we=1 only for waddr 0,1,128,129 (cycles 5,6,8,9), done at cycle 10.
- Hold brush at (10,20) colour 2, then change newColor to 3'd5: a second 9-write stroke with wdata=5. Then brush=0 one cycle and brush=1 at the same point/colour: a third stroke occurs.
- brush=1 with wx=130 or wy=200: no writes, busy stays 0.
- clear pulse in IDLE: 16384 writes of 3'd0, addresses 0..16383 in order, done at cycle 16385. clear asserted on the 4th cycle of a paint: paint writes stop, CLEAR begins next cycle at addr 0.
- reset asserted mid-CLEAR at addr ~500: we/busy drop immediately. After reset release, an identical held stroke repaints because the record is invalid.
